// File: rtl/usec_pulse_meter.sv
// Pulse-width meter in 1 us ticks; edge-to-strobe latency 2 clk on both edges so sync delay cancels.
// No backpressure: valid/timeout are one-cycle strobes, start is dropped unless idle.
module usec_pulse_meter #(
    parameter int MAX_US = 30000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             tick_usec,
    input  logic             start,
    input  logic             pulse_in,
    output logic             busy,
    output logic [CNT_W-1:0] width_us,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_US);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2, s3;
    logic             rise, fall;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state    <= IDLE;
            cnt      <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            width_us <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            s1      <= pulse_in;
            s2      <= s1;
            s3      <= s2;
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_RISE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_RISE: begin
                    // An edge wins over a coincident tick; that tick is simply lost.
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= '0;
                    end else if (tick_usec) begin
                        if (cnt == MAX_CNT) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        valid    <= 1'b1;
                        width_us <= cnt;
                    end else if (tick_usec) begin
                        if (cnt == MAX_CNT) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usec_pulse_meter.sv
// Directed bench for usec_pulse_meter with MAX_US=600 so a 580 us pulse fits and timeouts stay short.
module tb_usec_pulse_meter;

    localparam int MAX_US = 600;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             reset_p = 1'b1;
    logic             tick_usec = 1'b0;
    logic             start = 1'b0;
    logic             pulse_in = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] width_us;
    logic             valid;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_tmo    = 0;
    int n_both   = 0;
    int n_busy_strobe = 0;
    int n_wide   = 0;
    logic prev_valid = 1'b0;
    logic prev_tmo   = 1'b0;
    int v0, t0;

    usec_pulse_meter #(.MAX_US(MAX_US), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .tick_usec (tick_usec),
        .start     (start),
        .pulse_in  (pulse_in),
        .busy      (busy),
        .width_us  (width_us),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (timeout) n_tmo++;
        if (valid && timeout) n_both++;
        if ((valid || timeout) && busy) n_busy_strobe++;
        if ((valid && prev_valid) || (timeout && prev_tmo)) n_wide++;
        prev_valid = valid;
        prev_tmo   = timeout;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n ticks, each the last cycle of a period-clk window; entered and left at posedge+1
    task automatic run_ticks(input int n, input int period);
        repeat (n) begin
            repeat (period - 1) @(posedge clk);
            #1;
            tick_usec = 1'b1;
            @(posedge clk);
            #1;
            tick_usec = 1'b0;
        end
    endtask

    task automatic arm();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for 3 clk while inputs toggle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pulse_in = ~pulse_in;
            start    = ~start;
            @(negedge clk);
            check("rst_busy", int'(busy), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_timeout", int'(timeout), 0);
            check("rst_width", int'(width_us), 0);
        end
        @(posedge clk);
        #1;
        reset_p  = 1'b0;
        start    = 1'b0;
        pulse_in = 1'b0;
        wait_clk(5);
        check("idle_busy", int'(busy), 0);

        // nominal 580 us pulse, 100 clk per tick
        v0 = n_valid;
        arm();
        check("arm_busy", int'(busy), 1);
        run_ticks(20, 100);
        pulse_in = 1'b1;
        run_ticks(580, 100);
        pulse_in = 1'b0;
        run_ticks(5, 100);
        check("nom_valid_cnt", n_valid - v0, 1);
        check("nom_width_in_range", int'(width_us >= 579 && width_us <= 581), 1);
        check("nom_width", int'(width_us), 580);
        check("nom_busy_after", int'(busy), 0);

        // no echo: 600 ticks still busy, the 601st times out
        v0 = n_valid;
        t0 = n_tmo;
        arm();
        run_ticks(600, 2);
        check("noecho_busy_at_max", int'(busy), 1);
        check("noecho_no_early_tmo", int'(timeout), 0);
        run_ticks(1, 2);
        check("noecho_timeout", int'(timeout), 1);
        check("noecho_busy_low", int'(busy), 0);
        wait_clk(1);
        check("noecho_tmo_one_clk", int'(timeout), 0);
        wait_clk(3);
        check("noecho_tmo_cnt", n_tmo - t0, 1);
        check("noecho_no_valid", n_valid - v0, 0);
        check("noecho_width_kept", int'(width_us), 580);

        // stuck high: first tick after rise lands in WAIT_RISE, then 600 in MEASURE
        v0 = n_valid;
        t0 = n_tmo;
        arm();
        run_ticks(5, 2);
        pulse_in = 1'b1;
        run_ticks(601, 2);
        check("stuck_busy_at_max", int'(busy), 1);
        check("stuck_no_early_tmo", int'(timeout), 0);
        run_ticks(1, 2);
        check("stuck_timeout", int'(timeout), 1);
        pulse_in = 1'b0;
        wait_clk(6);
        check("stuck_tmo_cnt", n_tmo - t0, 1);
        check("stuck_no_valid", n_valid - v0, 0);
        check("stuck_width_kept", int'(width_us), 580);
        check("stuck_busy_low", int'(busy), 0);

        // armed while high: that pulse is skipped; next pulse 50 us with a stray start mid-measure
        v0 = n_valid;
        pulse_in = 1'b1;
        wait_clk(4);
        arm();
        run_ticks(10, 2);
        pulse_in = 1'b0;
        wait_clk(4);
        check("high_skip_busy", int'(busy), 1);
        check("high_skip_no_valid", n_valid - v0, 0);
        pulse_in = 1'b1;
        wait_clk(3);
        run_ticks(20, 2);
        arm();
        run_ticks(30, 2);
        pulse_in = 1'b0;
        wait_clk(4);
        check("second_pulse_valid_cnt", n_valid - v0, 1);
        check("second_pulse_width", int'(width_us), 50);

        // falling edge detected in the same cycle as a tick: that tick not counted
        v0 = n_valid;
        arm();
        pulse_in = 1'b1;
        wait_clk(3);
        run_ticks(3, 2);
        pulse_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tick_usec = 1'b1;
        @(posedge clk);
        #1;
        tick_usec = 1'b0;
        check("coinc_valid", int'(valid), 1);
        check("coinc_busy_low", int'(busy), 0);
        check("coinc_width", int'(width_us), 3);

        // back-to-back start in the cycle after valid
        arm();
        check("b2b_busy", int'(busy), 1);
        check("b2b_valid_low", int'(valid), 0);

        // reset in MEASURE discards the measurement
        t0 = n_tmo;
        pulse_in = 1'b1;
        wait_clk(3);
        run_ticks(5, 2);
        check("midrst_busy_before", int'(busy), 1);
        reset_p = 1'b1;
        wait_clk(1);
        reset_p = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_timeout", int'(timeout), 0);
        check("midrst_width", int'(width_us), 0);
        pulse_in = 1'b0;
        run_ticks(3, 2);
        wait_clk(3);
        check("midrst_no_valid", n_valid - v0, 1);
        check("midrst_no_tmo", n_tmo - t0, 0);

        check("total_valid", n_valid, 3);
        check("total_timeout", n_tmo, 2);
        check("strobe_both_high", n_both, 0);
        check("strobe_while_busy", n_busy_strobe, 0);
        check("strobe_wider_than_1", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
